memoria_fifo_param: RTL and testbench

Parametrised synchronous FIFO buffer for the ADC → FIR sample path. It replaces the vendor FIFO-IP wrapper with inferred RAM, so it needs no IP core. Writes are gated by the upstream ready_i qualifier. Read data is registered and forced to zero when no read is in progress. Additions over the previous generation:
- generic width and depth
- fill level and almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous clear
- optional first-word-fall-through (FWFT) mode

---
 rtl/memoria_fifo_param.sv | 122 ++++++++++++
 tb/tb_memoria_fifo_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/memoria_fifo_param.sv
// Parametrised synchronous FIFO with inferred RAM, level/threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default build uses one-cycle registered reads.
module memoria_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 2**ADDR_W - 2,
  parameter int AE_THRESH = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] dato_in_i,
  input  logic              wr_en_i,
  input  logic              ready_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] dato_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   level, level_nxt;
  logic              push, push_ok, pop_ok;
  logic              full_flag, empty_flag, af_flag, ae_flag, ovf_flag, udf_flag;
  logic [DATA_W-1:0] rd_data_p0, rd_data_p1;
  logic              vld_p0, vld_p1;

  // Stage p0: acceptance, next-state level and next output word
  always_comb begin
    push       = wr_en_i & ready_i;
    pop_ok     = rd_en_i & ~empty_flag & ~clr_i;
    push_ok    = push & (~full_flag | pop_ok) & ~clr_i;
    rd_ptr_nxt = pop_ok ? rd_ptr + ADDR_W'(1) : rd_ptr;
    level_nxt  = level;
    case ({push_ok, pop_ok})
      2'b10:   level_nxt = level + (ADDR_W+1)'(1);
      2'b01:   level_nxt = level - (ADDR_W+1)'(1);
      default: level_nxt = level;
    endcase
`ifdef FIFO_FWFT_EN
    // Head is the incoming word when nothing else survives this edge.
    vld_p0 = (level_nxt != '0);
    if (level_nxt == '0)
      rd_data_p0 = '0;
    else if (level == (ADDR_W+1)'(pop_ok))
      rd_data_p0 = dato_in_i;
    else
      rd_data_p0 = mem[rd_ptr_nxt];
`else
    vld_p0     = pop_ok;
    rd_data_p0 = pop_ok ? mem[rd_ptr] : '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= dato_in_i;
  end

  // Stage p1: registered pointers, level, flags and output word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full_flag  <= 1'b0;
      empty_flag <= 1'b1;
      af_flag    <= 1'b0;
      ae_flag    <= 1'b1;
      ovf_flag   <= 1'b0;
      udf_flag   <= 1'b0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full_flag  <= 1'b0;
      empty_flag <= 1'b1;
      af_flag    <= 1'b0;
      ae_flag    <= 1'b1;
      ovf_flag   <= 1'b0;
      udf_flag   <= 1'b0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      level      <= level_nxt;
      full_flag  <= (level_nxt == FULL_LVL);
      empty_flag <= (level_nxt == '0);
      af_flag    <= (level_nxt >= AF_LVL);
      ae_flag    <= (level_nxt <= AE_LVL);
      ovf_flag   <= ovf_flag | (push & ~push_ok);
      udf_flag   <= udf_flag | (rd_en_i & empty_flag);
      rd_data_p1 <= rd_data_p0;
      vld_p1     <= vld_p0;
    end
  end

  assign dato_o         = rd_data_p1;
  assign valid_o        = vld_p1;
  assign full_o         = full_flag;
  assign empty_o        = empty_flag;
  assign almost_full_o  = af_flag;
  assign almost_empty_o = ae_flag;
  assign level_o        = level;
  assign overflow_o     = ovf_flag;
  assign underflow_o    = udf_flag;

endmodule

// File: tb/tb_memoria_fifo_param.sv
// Bench for memoria_fifo_param: directed scenarios plus randomized traffic against a queue model.
// Honours FIFO_FWFT_EN in the model so the same bench covers both output modes.
module tb_memoria_fifo_param;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF_TH  = 14;
  localparam int AE_TH  = 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clr_i;
  logic [DATA_W-1:0] dato_in_i;
  logic              wr_en_i, ready_i, rd_en_i;
  logic [DATA_W-1:0] dato_o;
  logic              valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [ADDR_W:0]   level_o;
  logic              overflow_o, underflow_o;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int q[$];
  int exp_d;
  bit exp_v, exp_ov, exp_un;

  memoria_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .dato_in_i(dato_in_i),
    .wr_en_i(wr_en_i), .ready_i(ready_i), .rd_en_i(rd_en_i),
    .dato_o(dato_o), .valid_o(valid_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_d  = 0;
    exp_v  = 0;
    exp_ov = 0;
    exp_un = 0;
  endtask

  task automatic model_edge(input bit wr, input bit rdy, input bit rd, input int din, input bit clr);
    bit push, pop_ok, push_ok;
    if (clr) begin
      model_reset();
      return;
    end
    push    = wr && rdy;
    pop_ok  = rd && (q.size() > 0);
    push_ok = push && ((q.size() < DEPTH) || pop_ok);
    if (rd && q.size() == 0) exp_un = 1;
    if (push && !push_ok)    exp_ov = 1;
    exp_d = 0;
    exp_v = 0;
    if (pop_ok) begin
      exp_d = q.pop_front();
      exp_v = 1;
    end
    if (push_ok) q.push_back(din);
`ifdef FIFO_FWFT_EN
    exp_v = (q.size() != 0);
    exp_d = (q.size() != 0) ? q[0] : 0;
`endif
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".level"},  32'(level_o),        32'(q.size()));
    check_val({tag, ".full"},   32'(full_o),         32'(q.size() == DEPTH));
    check_val({tag, ".empty"},  32'(empty_o),        32'(q.size() == 0));
    check_val({tag, ".afull"},  32'(almost_full_o),  32'(q.size() >= AF_TH));
    check_val({tag, ".aempty"}, 32'(almost_empty_o), 32'(q.size() <= AE_TH));
    check_val({tag, ".ovf"},    32'(overflow_o),     32'(exp_ov));
    check_val({tag, ".udf"},    32'(underflow_o),    32'(exp_un));
    check_val({tag, ".valid"},  32'(valid_o),        32'(exp_v));
    check_val({tag, ".dato"},   32'(dato_o),         32'(exp_d));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare just after it.
  task automatic step(input string tag, input bit wr, input bit rdy, input bit rd,
                      input int din, input bit clr);
    wr_en_i   = wr;
    ready_i   = rdy;
    rd_en_i   = rd;
    dato_in_i = din[DATA_W-1:0];
    clr_i     = clr;
    @(posedge clk_i);
    model_edge(wr, rdy, rd, din, clr);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int pw, pr;
    rst_ni = 1'b0; clr_i = 1'b0; wr_en_i = 1'b0; ready_i = 1'b0;
    rd_en_i = 1'b0; dato_in_i = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    compare_all("post_reset");

    for (int i = 0; i < 3; i++) step("ready_gate", 1, 0, 0, 16'h5555, 0);

    for (int i = 1; i <= 16; i++) step("fill", 1, 1, 0, i, 0);
    step("overflow", 1, 1, 0, 16'h0011, 0);

    for (int i = 0; i < 16; i++) begin
      step("drain", 0, 0, 1, 0, 0);
      step("drain_idle", 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 10; i++) step("refill", 1, 1, 0, 16'h0100 + i, 0);
    for (int i = 0; i < 10; i++) step("wrap_drain", 0, 1, 1, 0, 0);
    step("udf_empty", 0, 1, 1, 0, 0);
    step("idle", 0, 0, 0, 0, 0);

    step("pp_empty", 1, 1, 1, 16'h00BB, 0);
    step("pop_bb", 0, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) step("fill2", 1, 1, 0, 16'h0200 + i, 0);
    step("pp_full", 1, 1, 1, 16'h00AA, 0);
    for (int i = 0; i < 9; i++) step("to_seven", 0, 0, 1, 0, 0);
    step("clr", 1, 1, 1, 16'h7777, 1);
    step("after_clr", 0, 0, 0, 0, 0);

    step("fwft_wr", 1, 1, 0, 16'h1234, 0);
    step("fwft_hold", 0, 0, 0, 0, 0);
    step("fwft_pop", 0, 0, 1, 0, 0);

    for (int i = 0; i < 5; i++) step("pre_rst", 1, 1, 0, 16'h0300 + i, 0);
    #3 rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk_i); #1;
    compare_all("rst_hold");
    #3 rst_ni = 1'b1;
    step("rst_release", 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      case ((n / 200) % 3)
        0:       begin pw = 85; pr = 30; end
        1:       begin pw = 30; pr = 85; end
        default: begin pw = 60; pr = 60; end
      endcase
      step("rand",
           $urandom_range(99) < pw,
           $urandom_range(99) < 85,
           $urandom_range(99) < pr,
           int'($urandom_range(16'hFFFF)),
           $urandom_range(199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
